// File: rtl/divisor_count_pkg.sv
// Shared definitions for the divisor-count engine: default widths, FSM encoding
// and a constant ceil-log2 helper used to size counters.
package divisor_count_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_RES_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_STEP  = 3'd3,
    S_TAIL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divisor_count_if.sv
// Request/response bundle between a requester and the divisor-count engine,
// plus a debug view of the engine FSM state.
interface divisor_count_if
  import divisor_count_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RES_WIDTH = DEF_RES_WIDTH
) ();

  // Four-phase level handshake: the requester raises start with value stable;
  // the engine latches value on leaving IDLE and raises done with result valid;
  // the requester then drops start, done falls one cycle later, and start must
  // stay low at least one cycle before the next request. Dropping start while
  // busy aborts the request with no done.
  logic                 start;
  logic [WIDTH-1:0]     value;
  logic [RES_WIDTH-1:0] result;
  logic                 done;
  logic                 busy;
  state_t               state;

  modport master (
    output start, value,
    input  result, done, busy, state
  );

  modport slave (
    input  start, value,
    output result, done, busy, state
  );

endinterface

// File: rtl/divisor_count_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses WIDTH+1
// cycles after the start pulse. A new start restarts it immediately.
module divisor_count_seq_divider
  import divisor_count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);

  localparam int CW = clog2(WIDTH + 1);

  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // A set top bit of the trial difference is the borrow: the divisor did not fit.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, den_q};
  assign fits    = ~diff[WIDTH];

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    den_d  = den_q;
    done_d = 1'b0;
    if (start_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      den_d  = divisor_i;
      cnt_d  = CW'(WIDTH);
      run_d  = 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        rem_d  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], fits};
        cnt_d  = cnt_q - CW'(1);
      end else begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      done_q <= done_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign done_o = done_q;

endmodule

// File: rtl/divisor_count.sv
// Divisor-count engine: d(N) by trial-division factorisation, d(N) = prod(e_i+1).
// Trial divisors are 2 then odd numbers while d*d <= remaining n.
module divisor_count
  import divisor_count_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RES_WIDTH = DEF_RES_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  divisor_count_if.slave bus
);

  localparam int DW = WIDTH / 2 + 1;
  localparam int W2 = 2 * WIDTH;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [DW-1:0]        d_q, d_d;
  logic [RES_WIDTH-1:0] e_q, e_d;
  logic [RES_WIDTH-1:0] cnt_q, cnt_d;
  logic [RES_WIDTH-1:0] result_q, result_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 div_start;
  logic [WIDTH-1:0]     div_quot;
  logic [WIDTH-1:0]     div_rem;
  logic                 div_done;

  logic [W2-1:0]        d_sq;
  logic [RES_WIDTH-1:0] cnt_mul;
  logic [RES_WIDTH-1:0] tail_cnt;

  assign d_sq     = W2'(d_q) * W2'(d_q);
  assign cnt_mul  = cnt_q * (e_q + RES_WIDTH'(1));
  // Whatever survives trial division above sqrt is a single prime factor.
  assign tail_cnt = (n_q > WIDTH'(1)) ? {cnt_q[RES_WIDTH-2:0], 1'b0} : cnt_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    e_d       = e_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = done_q;
    busy_d    = busy_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d   = bus.value;
          cnt_d = RES_WIDTH'(1);
          d_d   = DW'(2);
          e_d   = '0;
          if (bus.value == '0) begin
            result_d = '0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (bus.value == WIDTH'(1)) begin
            result_d = RES_WIDTH'(1);
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (!bus.start) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (d_sq > W2'(n_q)) begin
          state_d = S_TAIL;
        end else begin
          div_start = 1'b1;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        if (!bus.start) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (div_done) begin
          if (div_rem == '0) begin
            // Divides again: keep dividing the reduced n by the same d.
            n_d       = div_quot;
            e_d       = e_q + RES_WIDTH'(1);
            div_start = 1'b1;
          end else begin
            cnt_d   = cnt_mul;
            e_d     = '0;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (!bus.start) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          d_d     = (d_q == DW'(2)) ? DW'(3) : d_q + DW'(2);
          state_d = S_CHECK;
        end
      end
      S_TAIL: begin
        if (!bus.start) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d    = tail_cnt;
          result_d = tail_cnt;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      d_q      <= '0;
      e_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      e_q      <= e_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Dividend comes from n_d so a relaunch in DIV uses the fresh quotient.
  divisor_count_seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (div_start),
    .dividend_i(n_d),
    .divisor_i (WIDTH'(d_q)),
    .quot_o    (div_quot),
    .rem_o     (div_rem),
    .done_o    (div_done)
  );

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_divisor_count.sv
// Directed bench for divisor_count: driver tasks issue requests and push the
// expected d(N); a monitor pops and compares on every rising done.
module tb_divisor_count;
  import divisor_count_pkg::*;

  localparam int WIDTH     = 32;
  localparam int RES_WIDTH = 32;
  localparam int BUDGET    = 20000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divisor_count_if #(.WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH)) bus ();

  divisor_count #(
    .WIDTH    (WIDTH),
    .RES_WIDTH(RES_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [RES_WIDTH-1:0] exp_q[$];
  logic [RES_WIDTH-1:0] exp_v;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: result %0d with no request pending", bus.result);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(exp_v));
      end
    end
    done_prev <= bus.done;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge where done has been seen low.
  task automatic do_req(input logic [WIDTH-1:0] v, input logic [RES_WIDTH-1:0] expv,
                        input int max_cycles, input string tag);
    int cyc;
    bus.value = v;
    bus.start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    cyc = 1;
    if (v > WIDTH'(1)) check({tag, "_busy"}, 64'(bus.busy), 64'(1));
    bus.value = WIDTH'($urandom());
    while (!bus.done && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL %s_timeout: done still 0 after %0d cycles, required within %0d", tag, cyc, max_cycles);
    end
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_done_fall"}, 64'(bus.done), 64'(0));
    check({tag, "_state_idle"}, 64'(bus.state), 64'(S_IDLE));
  endtask

  task automatic wait_state(input state_t s, input int max_cycles, input string tag);
    int cyc;
    cyc = 0;
    while (bus.state != s && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_reach_state"}, 64'(bus.state), 64'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.value = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_done",   64'(bus.done),   64'(0));
    check("rst_busy",   64'(bus.busy),   64'(0));
    check("rst_state",  64'(bus.state),  64'(S_IDLE));
    rst_n = 1'b1;

    do_req(32'd28, 32'd6, 1000, "n28");
    do_req(32'd0,  32'd0, 3, "n0");
    do_req(32'd1,  32'd1, 3, "n1");
    do_req(32'd76576500, 32'd576, BUDGET, "n76576500");
    do_req(32'd65521,    32'd2,   BUDGET, "n65521");
    do_req(32'd1024,     32'd11,  BUDGET, "n1024");
    do_req(32'd36, 32'd9, BUDGET, "n36");
    do_req(32'd37, 32'd2, BUDGET, "n37");

    // Abort mid-divide: no done, result keeps the previous answer (2).
    bus.value = 32'd97;
    bus.start = 1'b1;
    @(negedge clk);
    wait_state(S_DIV, 20, "abort97");
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_state",  64'(bus.state),  64'(S_IDLE));
    check("abort_busy",   64'(bus.busy),   64'(0));
    check("abort_done",   64'(bus.done),   64'(0));
    check("abort_result", 64'(bus.result), 64'(2));
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(bus.done), 64'(0));
    do_req(32'd12, 32'd6, BUDGET, "n12");

    // Reset pulse mid-operation discards the request.
    bus.value = 32'd720720;
    bus.start = 1'b1;
    repeat (50) @(negedge clk);
    check("pre_rst_busy", 64'(bus.busy), 64'(1));
    rst_n     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_result", 64'(bus.result), 64'(0));
    check("midrst_done",   64'(bus.done),   64'(0));
    check("midrst_busy",   64'(bus.busy),   64'(0));
    check("midrst_state",  64'(bus.state),  64'(S_IDLE));
    do_req(32'd720720, 32'd240, BUDGET, "n720720");

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
